// File: rtl/vector_line_engine.sv
// Vector command engine: accepts move/line commands and streams beam samples,
// rasterising lines with Bresenham steps under valid/ready backpressure.
module vector_line_engine #(
    parameter int OUT_WIDTH = 8,
    parameter int ERR_WIDTH = OUT_WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OUT_WIDTH-1:0] in_x,
    input  logic [OUT_WIDTH-1:0] in_y,
    input  logic                 in_pos,
    input  logic                 in_line,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_x,
    output logic [OUT_WIDTH-1:0] out_y,
    output logic                 out_blank,
    output logic                 out_last,
    output logic                 busy
);
    // Both ports: a transfer happens on a rising edge where valid && ready;
    // out_valid and the sample fields stay stable until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, DRAW = 2'd2, MOVE = 2'd3} state_t;

    localparam logic [OUT_WIDTH-1:0] ONE = OUT_WIDTH'(1);
    localparam logic [OUT_WIDTH-1:0] TWO = OUT_WIDTH'(2);

    state_t state, state_nxt;

    logic [OUT_WIDTH-1:0]        cur_x, cur_y, tgt_x, tgt_y, px, py, cnt;
    logic                        last_r, x_inc, y_inc;
    logic signed [ERR_WIDTH-1:0] dx, dy, err;

    logic                        accept, out_hs;
    logic [OUT_WIDTH-1:0]        adx, ady, len;
    logic                        x_inc0, y_inc0;
    logic signed [ERR_WIDTH-1:0] dx0, dy0;

    logic [OUT_WIDTH-1:0]        st_px, st_py, nxt_px, nxt_py;
    logic                        st_xi, st_yi, step_x, step_y;
    logic signed [ERR_WIDTH-1:0] st_err, st_dx, st_dy, nxt_err;
    logic signed [ERR_WIDTH:0]   e2, dx_e, dy_e;

    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Line parameters derived from the current position and latched target.
    always_comb begin
        x_inc0 = (tgt_x >= cur_x);
        y_inc0 = (tgt_y >= cur_y);
        adx    = x_inc0 ? (tgt_x - cur_x) : (cur_x - tgt_x);
        ady    = y_inc0 ? (tgt_y - cur_y) : (cur_y - tgt_y);
        len    = (adx >= ady) ? adx : ady;
        dx0    = $signed(ERR_WIDTH'(adx));
        dy0    = -$signed(ERR_WIDTH'(ady));
    end

    // One Bresenham step; SETUP feeds it the fresh line so the first sample
    // is ready one cycle after setup instead of two.
    always_comb begin
        if (state == SETUP) begin
            st_px  = cur_x;
            st_py  = cur_y;
            st_err = dx0 + dy0;
            st_dx  = dx0;
            st_dy  = dy0;
            st_xi  = x_inc0;
            st_yi  = y_inc0;
        end else begin
            st_px  = px;
            st_py  = py;
            st_err = err;
            st_dx  = dx;
            st_dy  = dy;
            st_xi  = x_inc;
            st_yi  = y_inc;
        end
        e2     = $signed({st_err, 1'b0});
        dx_e   = {st_dx[ERR_WIDTH-1], st_dx};
        dy_e   = {st_dy[ERR_WIDTH-1], st_dy};
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        nxt_err = st_err;
        if (step_x) nxt_err = nxt_err + st_dy;
        if (step_y) nxt_err = nxt_err + st_dx;
        nxt_px = st_px;
        if (step_x) nxt_px = st_xi ? (st_px + ONE) : (st_px - ONE);
        nxt_py = st_py;
        if (step_y) nxt_py = st_yi ? (st_py + ONE) : (st_py - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) begin
                       if (in_pos)       state_nxt = MOVE;
                       else if (in_line) state_nxt = SETUP;
                   end
            SETUP: state_nxt = DRAW;
            DRAW:  if (out_hs && cnt == ONE) state_nxt = IDLE;
            MOVE:  if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x     <= '0;
            cur_y     <= '0;
            tgt_x     <= '0;
            tgt_y     <= '0;
            px        <= '0;
            py        <= '0;
            cnt       <= '0;
            last_r    <= 1'b0;
            x_inc     <= 1'b0;
            y_inc     <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_blank <= 1'b1;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // No-op commands are consumed without touching any state.
                    if (accept && (in_pos || in_line)) begin
                        tgt_x  <= in_x;
                        tgt_y  <= in_y;
                        last_r <= in_last;
                    end
                    if (accept && in_pos) begin
                        out_valid <= 1'b1;
                        out_x     <= in_x;
                        out_y     <= in_y;
                        out_blank <= 1'b1;
                        out_last  <= in_last;
                    end
                end
                SETUP: begin
                    dx        <= dx0;
                    dy        <= dy0;
                    x_inc     <= x_inc0;
                    y_inc     <= y_inc0;
                    out_valid <= 1'b1;
                    out_blank <= 1'b0;
                    if (len == '0) begin
                        cnt      <= ONE;
                        out_x    <= tgt_x;
                        out_y    <= tgt_y;
                        out_last <= last_r;
                    end else begin
                        cnt      <= len;
                        px       <= nxt_px;
                        py       <= nxt_py;
                        err      <= nxt_err;
                        out_x    <= nxt_px;
                        out_y    <= nxt_py;
                        out_last <= last_r && (len == ONE);
                    end
                end
                DRAW: begin
                    if (out_hs) begin
                        if (cnt == ONE) begin
                            cur_x     <= tgt_x;
                            cur_y     <= tgt_y;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            cnt      <= cnt - ONE;
                            px       <= nxt_px;
                            py       <= nxt_py;
                            err      <= nxt_err;
                            out_x    <= nxt_px;
                            out_y    <= nxt_py;
                            out_last <= last_r && (cnt == TWO);
                        end
                    end
                end
                MOVE: begin
                    if (out_hs) begin
                        cur_x     <= tgt_x;
                        cur_y     <= tgt_y;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_line_engine.sv
// Bench for vector_line_engine: directed scenarios plus randomized commands,
// each compared against a point-list model of the command stream.
module tb_vector_line_engine;
    localparam int W  = 10;
    localparam int SW = 2 * W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic         in_pos = 1'b0;
    logic         in_line = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic         out_blank;
    logic         out_last;
    logic         busy;

    vector_line_engine #(.OUT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_pos(in_pos), .in_line(in_line), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_blank(out_blank), .out_last(out_last),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 5ms", $time);
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] obs_q[$];
    int acc_cyc, first_cyc, first_hs, last_hs, end_cyc, hold_viol;
    bit timeout;
    int mx, my;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mx = 0;
        my = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [SW-1:0] mk(int x, int y, bit b, bit l);
        return {W'(x), W'(y), b, l};
    endfunction

    function automatic void model_line(int x1, int y1, bit last);
        int x, y, ddx, ddy, sx, sy, e, e2;
        x = mx; y = my;
        ddx = (x1 > x) ? x1 - x : x - x1;
        ddy = -((y1 > y) ? y1 - y : y - y1);
        sx = (x1 >= x) ? 1 : -1;
        sy = (y1 >= y) ? 1 : -1;
        e = ddx + ddy;
        if (x == x1 && y == y1) exp_q.push_back(mk(x1, y1, 1'b0, last));
        while (!(x == x1 && y == y1)) begin
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; x += sx; end
            if (e2 <= ddx) begin e += ddx; y += sy; end
            exp_q.push_back(mk(x, y, 1'b0, last && x == x1 && y == y1));
        end
        mx = x1; my = y1;
    endfunction

    function automatic void model_cmd(int x, int y, bit pos, bit line, bit last);
        if (pos) begin
            exp_q.push_back(mk(x, y, 1'b1, last));
            mx = x; my = y;
        end else if (line) begin
            model_line(x, y, last);
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input int x, input int y, input bit pos, input bit line, input bit last);
        int k;
        k = 0;
        @(negedge clk);
        in_x = W'(x); in_y = W'(y);
        in_pos = pos; in_line = line; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // mode 0: ready always, 1: ready toggles, 2: random ready
    task automatic drain(input int mode, input int max_hs, input int budget);
        logic [SW-1:0] cur_s, prev_s;
        bit prev_stall;
        obs_q.delete();
        hold_viol = 0; first_cyc = -1; first_hs = -1; last_hs = -1;
        timeout = 1'b0; prev_stall = 1'b0; prev_s = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (obs_q.size() >= max_hs || (!out_valid && !busy)) begin
                out_ready = 1'b0;
                end_cyc = cyc;
                return;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (i % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cur_s = {out_x, out_y, out_blank, out_last};
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (prev_stall && (!out_valid || cur_s !== prev_s)) hold_viol++;
            prev_stall = out_valid && !out_ready;
            prev_s = cur_s;
            if (out_valid && out_ready) begin
                obs_q.push_back(cur_s);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
        end
        timeout = 1'b1;
        out_ready = 1'b0;
        end_cyc = cyc;
    endtask

    task automatic run(input int x, input int y, input bit pos, input bit line, input bit last,
                       input int mode, input int max_hs, input int budget);
        exp_q.delete();
        model_cmd(x, y, pos, line, last);
        send(x, y, pos, line, last);
        drain(mode, max_hs, budget);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_x = W'(7); in_y = W'(9); in_pos = 1'b1; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001)
            $display("FAIL reset_ctrl: valid/busy/ready got %b want 001", {out_valid, busy, in_ready});
        else n_pass++;
        n_checks++;
        if ({out_x, out_y, out_blank, out_last} !== mk(0, 0, 1'b1, 1'b0))
            $display("FAIL reset_sample: got %h want %h", {out_x, out_y, out_blank, out_last}, mk(0, 0, 1'b1, 1'b0));
        else n_pass++;
        in_valid = 1'b0; in_pos = 1'b0;
        rst_n = 1'b1;
        mx = 0; my = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b00)
            $display("FAIL reset_ignore: valid/busy got %b want 00", {out_valid, busy});
        else n_pass++;
    endtask

    task automatic test_move_then_line();
        int d;
        do_reset();
        run(92, 148, 1'b1, 1'b0, 1'b0, 0, 10, 50);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL move_sample: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        n_checks++;
        if (first_cyc - acc_cyc + 1 !== 1) $display("FAIL move_latency: got %0d want 1", first_cyc - acc_cyc + 1);
        else n_pass++;
        run(80, 165, 1'b0, 1'b1, 1'b0, 0, 100, 200);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL line17_samples: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 17 || obs_q[16] !== mk(80, 165, 1'b0, 1'b0))
            $display("FAIL line17_end: count %0d last %h want 17 %h", obs_q.size(), obs_q[16], mk(80, 165, 1'b0, 1'b0));
        else n_pass++;
        n_checks++;
        if (first_cyc - acc_cyc + 1 !== 2) $display("FAIL line_latency: got %0d want 2", first_cyc - acc_cyc + 1);
        else n_pass++;
        run(81, 165, 1'b0, 1'b1, 1'b0, 0, 10, 50);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== mk(81, 165, 1'b0, 1'b0))
            $display("FAIL cur_after_line: count %0d got %h want 1 %h", obs_q.size(), obs_q[0], mk(81, 165, 1'b0, 1'b0));
        else n_pass++;
    endtask

    task automatic test_horizontal();
        int d;
        do_reset();
        run(5, 0, 1'b0, 1'b1, 1'b0, 0, 100, 100);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL horiz_samples: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 5 || obs_q[0] !== mk(1, 0, 1'b0, 1'b0) || obs_q[4] !== mk(5, 0, 1'b0, 1'b0))
            $display("FAIL horiz_points: count %0d first %h last %h want 5 %h %h", obs_q.size(), obs_q[0], obs_q[4],
                     mk(1, 0, 1'b0, 1'b0), mk(5, 0, 1'b0, 1'b0));
        else n_pass++;
        n_checks++;
        if (last_hs - first_hs !== 4) $display("FAIL horiz_rate: span got %0d want 4", last_hs - first_hs);
        else n_pass++;
        n_checks++;
        if (end_cyc !== last_hs + 1) $display("FAIL horiz_busy_drop: got cycle %0d want %0d", end_cyc, last_hs + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int d;
        do_reset();
        run(4, 4, 1'b0, 1'b1, 1'b0, 1, 100, 100);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL bp_samples: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 4 || obs_q[3] !== mk(4, 4, 1'b0, 1'b0))
            $display("FAIL bp_count: got %0d last %h want 4 %h", obs_q.size(), obs_q[3], mk(4, 4, 1'b0, 1'b0));
        else n_pass++;
        n_checks++;
        if (hold_viol !== 0) $display("FAIL bp_hold: unstable stalled samples got %0d want 0", hold_viol);
        else n_pass++;
    endtask

    task automatic test_degenerate();
        do_reset();
        run(10, 10, 1'b1, 1'b0, 1'b0, 0, 10, 50);
        run(10, 10, 1'b0, 1'b1, 1'b0, 0, 10, 50);
        n_checks++;
        if (timeout || obs_q.size() !== 1 || obs_q[0] !== mk(10, 10, 1'b0, 1'b0))
            $display("FAIL zero_len: count %0d got %h want 1 %h", obs_q.size(), obs_q[0], mk(10, 10, 1'b0, 1'b0));
        else n_pass++;
        run(50, 60, 1'b0, 1'b0, 1'b1, 0, 10, 50);
        n_checks++;
        if (obs_q.size() !== 0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL noop: count %0d ready %b busy %b want 0 1 0", obs_q.size(), in_ready, busy);
        else n_pass++;
        run(30, 40, 1'b1, 1'b1, 1'b0, 0, 10, 50);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== mk(30, 40, 1'b1, 1'b0))
            $display("FAIL pos_and_line: count %0d got %h want 1 %h", obs_q.size(), obs_q[0], mk(30, 40, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_last();
        int d, n_last;
        do_reset();
        run(20, 20, 1'b1, 1'b0, 1'b0, 0, 10, 50);
        run(23, 21, 1'b0, 1'b1, 1'b1, 2, 100, 100);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL last_samples: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        n_last = 0;
        foreach (obs_q[i]) n_last += int'(obs_q[i][0]);
        n_checks++;
        if (obs_q.size() !== 3 || n_last !== 1 || obs_q[2] !== mk(23, 21, 1'b0, 1'b1))
            $display("FAIL last_flag: count %0d flags %0d final %h want 3 1 %h", obs_q.size(), n_last, obs_q[2],
                     mk(23, 21, 1'b0, 1'b1));
        else n_pass++;
        run(0, 0, 1'b1, 1'b0, 1'b0, 0, 10, 50);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== mk(0, 0, 1'b1, 1'b0))
            $display("FAIL next_frame: got %h want %h", obs_q[0], mk(0, 0, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_reset_mid_line();
        int d;
        do_reset();
        run(92, 148, 1'b1, 1'b0, 1'b0, 0, 10, 50);
        run(80, 165, 1'b0, 1'b1, 1'b0, 0, 3, 100);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        n_checks++; d = first_diff();
        if (d != -1) $display("FAIL abort_prefix: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) $display("FAIL abort_now: valid/busy got %b want 00", {out_valid, busy});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        mx = 0; my = 0;
        run(2, 1, 1'b0, 1'b1, 1'b0, 0, 10, 50);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL abort_cur: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
    endtask

    task automatic test_long_diag();
        int d;
        do_reset();
        run(1023, 1023, 1'b0, 1'b1, 1'b1, 0, 2000, 1100);
        n_checks++; d = first_diff();
        if (d != -1 || timeout) $display("FAIL diag_samples: idx %0d got %h want %h", d, obs_q[d], exp_q[d]);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 1023 || obs_q[1022] !== mk(1023, 1023, 1'b0, 1'b1))
            $display("FAIL diag_end: count %0d last %h want 1023 %h", obs_q.size(), obs_q[1022],
                     mk(1023, 1023, 1'b0, 1'b1));
        else n_pass++;
    endtask

    task automatic test_random();
        int d, kind, x, y;
        bit pos, line, last;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            last = 1'($urandom_range(0, 1));
            if (kind <= 2) begin
                x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
                pos = 1'b1; line = 1'b0;
            end else begin
                x = mx + int'($urandom_range(0, 80)) - 40;
                y = my + int'($urandom_range(0, 80)) - 40;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                pos = (kind == 9) ? 1'($urandom_range(0, 1)) : 1'b0;
                line = (kind == 9) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            run(x, y, pos, line, last, 2, 1000, 600);
            n_checks++; d = first_diff();
            if (d != -1 || timeout || hold_viol != 0)
                $display("FAIL random_%0d: idx %0d got %h want %h hold %0d", it, d, obs_q[d], exp_q[d], hold_viol);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_move_then_line();
        test_horizontal();
        test_backpressure();
        test_degenerate();
        test_last();
        test_reset_mid_line();
        test_long_diag();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
